// File: rtl/mod_updown_counter.sv
// Modulo-MODULUS up/down counter with load, wrap/saturate mode, terminal-count pulse and sticky ovf.
// Optional step prescaler enabled by defining COUNTER_PRESCALE_EN.
module mod_updown_counter #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned MODULUS  = 256,
    parameter int unsigned PRESCALE = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             sat_mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             clear_ovf,
    output logic [WIDTH-1:0] value,
    output logic             tc,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);

    if (WIDTH < 2 || MODULUS < 2 || 64'(MODULUS) > (64'd1 << WIDTH) || PRESCALE < 1) begin : g_bad_params
        $error("mod_updown_counter: illegal WIDTH/MODULUS/PRESCALE combination");
    end

    logic step;

`ifdef COUNTER_PRESCALE_EN
    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] pre;

    assign step = en && (pre == PRE_LAST);

    // Prescaler advances only on en cycles; load restarts the step interval.
    always_ff @(posedge clk) begin
        if (reset || load) begin
            pre <= '0;
        end else if (en) begin
            pre <= (pre == PRE_LAST) ? '0 : pre + 1'b1;
        end
    end
`else
    assign step = en;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            value <= '0;
            tc    <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            tc <= 1'b0;
            if (clear_ovf) begin
                ovf <= 1'b0;
            end
            if (load) begin
                value <= (load_value > MAX) ? MAX : load_value;
            end else if (step) begin
                if (up) begin
                    if (value == MAX) begin
                        // Bound event: later ovf assignment overrides a same-cycle clear.
                        tc    <= 1'b1;
                        ovf   <= 1'b1;
                        value <= sat_mode ? MAX : '0;
                    end else begin
                        value <= value + 1'b1;
                    end
                end else begin
                    if (value == '0) begin
                        tc    <= 1'b1;
                        ovf   <= 1'b1;
                        value <= sat_mode ? '0 : MAX;
                    end else begin
                        value <= value - 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_mod_updown_counter.sv
// Self-checking bench for mod_updown_counter (WIDTH=8, MODULUS=200, PRESCALE=4).
// Directed vector table, hand sequences and randomized stimulus against an arithmetic model.
module tb_mod_updown_counter;

    localparam int WIDTH    = 8;
    localparam int MODULUS  = 200;
    localparam int PRESCALE = 4;
`ifdef COUNTER_PRESCALE_EN
    localparam int P_EFF = PRESCALE;
`else
    localparam int P_EFF = 1;
`endif

    logic             clk = 1'b0;
    logic             reset, en, up, sat_mode, load, clear_ovf;
    logic [WIDTH-1:0] load_value;
    logic [WIDTH-1:0] value;
    logic             tc, ovf;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_val = 0;
    int m_tc  = 0;
    int m_ovf = 0;
    int m_pre = 0;

    always #5 clk = ~clk;

    mod_updown_counter #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS),
        .PRESCALE(PRESCALE)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .up        (up),
        .sat_mode  (sat_mode),
        .load      (load),
        .load_value(load_value),
        .clear_ovf (clear_ovf),
        .value     (value),
        .tc        (tc),
        .ovf       (ovf)
    );

    typedef struct {
        logic       r, e, u, s, l;
        logic [7:0] lv;
        logic       c;
        int         ev;
        int         et;
        int         eo;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic r, e, u, s, l, input int lv, input logic c,
                                input int ev, et, eo);
        vec_t v;
        v.r = r; v.e = e; v.u = u; v.s = s; v.l = l; v.lv = 8'(lv); v.c = c;
        v.ev = ev; v.et = et; v.eo = eo;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input logic r, e, u, s, l, input int lv, input logic c);
        int nxt;
        int hit;
        hit = 0;
        if (r) begin
            m_val = 0; m_ovf = 0; m_pre = 0;
        end else if (l) begin
            m_val = (lv >= MODULUS) ? MODULUS - 1 : lv;
            m_pre = 0;
        end else if (e) begin
            m_pre = m_pre + 1;
            if (m_pre == P_EFF) begin
                m_pre = 0;
                nxt = u ? m_val + 1 : m_val - 1;
                if (nxt < 0 || nxt >= MODULUS) begin
                    hit = 1;
                    if (!s) m_val = (nxt + MODULUS) % MODULUS;
                end else begin
                    m_val = nxt;
                end
            end
        end
        if (!r) begin
            if (hit != 0) m_ovf = 1;
            else if (c) m_ovf = 0;
        end
        m_tc = hit;
    endtask

    task automatic apply(input logic r, e, u, s, l, input int lv, input logic c);
        reset = r; en = e; up = u; sat_mode = s; load = l;
        load_value = 8'(lv); clear_ovf = c;
        model_step(r, e, u, s, l, lv, c);
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        check({tag, ".value"}, int'(value), m_val);
        check({tag, ".tc"},    int'(tc),    m_tc);
        check({tag, ".ovf"},   int'(ovf),   m_ovf);
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; up = 1'b0; sat_mode = 1'b0; load = 1'b0;
        load_value = '0; clear_ovf = 1'b0;

        // r e u s l lv c  -> value tc ovf
        tbl.push_back(mk(1,0,0,0,0,  0,0,   0,0,0));
        tbl.push_back(mk(0,0,0,0,1, 57,0,  57,0,0));
        tbl.push_back(mk(0,1,1,0,0,  0,0,  58,0,0));
        tbl.push_back(mk(1,1,1,0,1,  9,0,   0,0,0));
        tbl.push_back(mk(1,1,1,0,0,  0,0,   0,0,0));
        tbl.push_back(mk(0,0,0,0,0,  0,0,   0,0,0));
        tbl.push_back(mk(0,0,0,0,1,198,0, 198,0,0));
        tbl.push_back(mk(0,1,1,0,0,  0,0, 199,0,0));
        tbl.push_back(mk(0,1,1,0,0,  0,0,   0,1,1));
        tbl.push_back(mk(0,1,1,0,0,  0,0,   1,0,1));
        tbl.push_back(mk(0,1,0,1,0,  0,0,   0,0,1));
        tbl.push_back(mk(0,1,0,1,0,  0,0,   0,1,1));
        tbl.push_back(mk(0,1,0,1,0,  0,0,   0,1,1));
        tbl.push_back(mk(0,0,0,1,0,  0,0,   0,0,1));
        tbl.push_back(mk(0,1,1,0,1,250,0, 199,0,1));
        tbl.push_back(mk(0,1,1,0,0,  0,1,   0,1,1));
        tbl.push_back(mk(0,0,0,0,0,  0,1,   0,0,0));
        tbl.push_back(mk(0,1,0,0,0,  0,0, 199,1,1));
        tbl.push_back(mk(0,0,0,0,1,200,0, 199,0,1));
        tbl.push_back(mk(0,0,0,0,1,255,1, 199,0,0));
        tbl.push_back(mk(0,1,1,1,0,  0,0, 199,1,1));
        tbl.push_back(mk(0,1,0,1,0,  0,0, 198,0,1));

        apply(1,0,0,0,0,0,0);
        check("reset.value", int'(value), 0);
        check("reset.tc",    int'(tc),    0);
        check("reset.ovf",   int'(ovf),   0);

`ifndef COUNTER_PRESCALE_EN
        foreach (tbl[i]) begin
            apply(tbl[i].r, tbl[i].e, tbl[i].u, tbl[i].s, tbl[i].l, int'(tbl[i].lv), tbl[i].c);
            check($sformatf("vec%0d.value", i), int'(value), tbl[i].ev);
            check($sformatf("vec%0d.tc", i),    int'(tc),    tbl[i].et);
            check($sformatf("vec%0d.ovf", i),   int'(ovf),   tbl[i].eo);
        end

        // Full wrap lap: tc exactly once, when value returns to 0.
        apply(0,0,0,0,1,0,1);
        for (int i = 1; i <= MODULUS; i++) begin
            apply(0,1,1,0,0,0,0);
            check($sformatf("lap%0d.value", i), int'(value), i % MODULUS);
            check($sformatf("lap%0d.tc", i),    int'(tc),    (i == MODULUS) ? 1 : 0);
        end
        check("lap.ovf", int'(ovf), 1);
`else
        if (PRESCALE == 4) begin
            // en pattern 1,1,0,1,1 from 10: step only on the 4th en cycle.
            apply(0,0,0,0,1,10,1);
            apply(0,1,1,0,0,0,0); check("pre.a1", int'(value), 10);
            apply(0,1,1,0,0,0,0); check("pre.a2", int'(value), 10);
            apply(0,0,1,0,0,0,0); check("pre.a3", int'(value), 10);
            apply(0,1,1,0,0,0,0); check("pre.a4", int'(value), 10);
            apply(0,1,1,0,0,0,0); check("pre.a5", int'(value), 11);
            // Load mid-interval restarts the count.
            apply(0,1,1,0,0,0,0);
            apply(0,1,1,0,1,10,0); check("pre.b0", int'(value), 10);
            apply(0,1,1,0,0,0,0); check("pre.b1", int'(value), 10);
            apply(0,1,1,0,0,0,0); check("pre.b2", int'(value), 10);
            apply(0,1,1,0,0,0,0); check("pre.b3", int'(value), 10);
            apply(0,1,1,0,0,0,0); check("pre.b4", int'(value), 11);
            check("pre.tc", int'(tc), 0);
        end
`endif

        // Randomized stimulus against the model.
        for (int i = 0; i < 600; i++) begin
            logic r, e, u, s, l, c;
            int   lv;
            r  = ($urandom_range(0, 40) == 0);
            e  = ($urandom_range(0, 3) != 0);
            u  = ($urandom_range(0, 1) == 1);
            s  = ($urandom_range(0, 2) == 0);
            l  = ($urandom_range(0, 9) == 0);
            c  = ($urandom_range(0, 7) == 0);
            case ($urandom_range(0, 3))
                0:       lv = $urandom_range(0, 2);
                1:       lv = $urandom_range(MODULUS - 3, MODULUS + 2);
                default: lv = $urandom_range(0, 255);
            endcase
            apply(r, e, u, s, l, lv, c);
            check_model($sformatf("rnd%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
